// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
// Bundles every non-clock/reset signal of the ID stage: the fetch-side offer
// handshake, the flush request, the register-file write-back port and the
// ID/EX pipeline register outputs with their consumer handshake.
//   slave  : the ID stage itself (takes the offer, drives ex_*)
//   master : the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  // control
  logic            flush;
  // write-back port
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  // execute side
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [11:0]     ex_ctrl;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rd, ex_rs1, ex_rs2, ex_ctrl, ex_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rd, ex_rs1, ex_rs2, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Handshaked RV32I/E decode stage. Decodes the offered instruction, reads
// the internal register file (optional same-cycle write-back bypass),
// detects load-use hazards against the instruction held in ID/EX and
// registers the result into a valid/ready ID/EX register with stall/flush.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    id_stage_pipe_if.slave: if_* offer, flush, wb_* write port,
//          ex_* pipeline register outputs and ex_ready
// ex_ctrl = {mem_read, mem_write, reg_write, alu_src,
//            mem_to_reg[1:0], jump[1:0], alu_op[3:0]}
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               reset,
  id_stage_pipe_if.slave     bus
);

  localparam int         REG_AW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     ctrl;
    logic            illegal;
  } ex_t;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  // x0 and out-of-range indices are never written; without the range check
  // a RV32E write to x17 would alias onto x1 through index truncation.
  assign wr_en = bus.wb_we && (bus.wb_rd != 5'd0) && ({1'b0, bus.wb_rd} < NREGS_L);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.wb_rd[REG_AW-1:0]] = bus.wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        known, uses_rs1, uses_rs2, uses_rd;
  logic        mem_read, mem_write, reg_write, alu_src;
  logic [1:0]  mem_to_reg, jump;
  logic [3:0]  alu_op;
  logic        idx_bad, illegal;
  logic [11:0] ctrl;

  assign inst    = bus.if_inst;
  assign opcode  = inst[6:0];
  assign f3      = inst[14:12];
  assign rd_idx  = inst[11:7];
  assign rs1_idx = inst[19:15];
  assign rs2_idx = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    known      = 1'b1;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    uses_rd    = 1'b0;
    imm32      = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 2'b00;
    jump       = 2'b00;
    alu_op     = {1'b0, f3};
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        uses_rd = 1'b1; reg_write = 1'b1; alu_src = 1'b1; imm32 = imm_u;
      end
      OP_JAL: begin
        uses_rd = 1'b1; reg_write = 1'b1; alu_src = 1'b1;
        mem_to_reg = 2'b10; jump = 2'b01; imm32 = imm_j;
      end
      OP_JALR: begin
        uses_rs1 = 1'b1; uses_rd = 1'b1; reg_write = 1'b1; alu_src = 1'b1;
        mem_to_reg = 2'b10; jump = 2'b10; imm32 = imm_i;
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; jump = 2'b11; imm32 = imm_b;
      end
      OP_LOAD: begin
        uses_rs1 = 1'b1; uses_rd = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
        alu_src = 1'b1; mem_to_reg = 2'b01; imm32 = imm_i;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; mem_write = 1'b1; alu_src = 1'b1;
        imm32 = imm_s;
      end
      OP_IMM: begin
        uses_rs1 = 1'b1; uses_rd = 1'b1; reg_write = 1'b1; alu_src = 1'b1;
        imm32 = imm_i;
        // only the right shifts use bit 30 to pick arithmetic vs logical
        if (f3 == 3'b101) alu_op[3] = inst[30];
      end
      OP_REG: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1; reg_write = 1'b1;
        alu_op[3] = inst[30];
      end
      default: known = 1'b0;
    endcase
  end

  // Only fields the format actually uses are range-checked, otherwise
  // immediate bits sitting in a register slot would flag RV32E code.
  always_comb begin
    idx_bad = (uses_rs1 && ({1'b0, rs1_idx} >= NREGS_L)) ||
              (uses_rs2 && ({1'b0, rs2_idx} >= NREGS_L)) ||
              (uses_rd  && ({1'b0, rd_idx}  >= NREGS_L));
    illegal = !known || idx_bad;
    ctrl    = illegal ? 12'h000
                      : {mem_read, mem_write, reg_write, alu_src, mem_to_reg, jump, alu_op};
  end

  // -------------------------------------------------------------------------
  // Operand read with optional write-back bypass
  // -------------------------------------------------------------------------
  logic            rs1_ok, rs2_ok, rs1_hit, rs2_hit;
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_ok  = uses_rs1 && (rs1_idx != 5'd0) && ({1'b0, rs1_idx} < NREGS_L);
    rs2_ok  = uses_rs2 && (rs2_idx != 5'd0) && ({1'b0, rs2_idx} < NREGS_L);
    rs1_hit = (BYPASS != 0) && wr_en && (bus.wb_rd == rs1_idx);
    rs2_hit = (BYPASS != 0) && wr_en && (bus.wb_rd == rs2_idx);
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_ok) rs1_val = rs1_hit ? bus.wb_data : regs_q[rs1_idx[REG_AW-1:0]];
    if (rs2_ok) rs2_val = rs2_hit ? bus.wb_data : regs_q[rs2_idx[REG_AW-1:0]];
  end

  // -------------------------------------------------------------------------
  // ID/EX pipeline register
  // -------------------------------------------------------------------------
  ex_t  ex_q, ex_d, dec_ex;
  logic valid_q, valid_d;
  logic stall, if_ready, accept;

  always_comb begin
    // load result is not available until after MEM, so a dependent
    // instruction must wait one cycle behind a bubble
    stall = valid_q && ex_q.ctrl[11] && (ex_q.rd != 5'd0) &&
            ((uses_rs1 && (ex_q.rd == rs1_idx)) || (uses_rs2 && (ex_q.rd == rs2_idx)));
    if_ready = (!valid_q || bus.ex_ready) && !stall && !bus.flush;
    accept   = bus.if_valid && if_ready;

    dec_ex.pc      = bus.if_pc;
    dec_ex.rs1_val = rs1_val;
    dec_ex.rs2_val = rs2_val;
    dec_ex.imm     = XLEN'($signed(imm32));
    dec_ex.rd      = uses_rd  ? rd_idx  : 5'd0;
    dec_ex.rs1     = uses_rs1 ? rs1_idx : 5'd0;
    dec_ex.rs2     = uses_rs2 ? rs2_idx : 5'd0;
    dec_ex.ctrl    = ctrl;
    dec_ex.illegal = illegal;

    valid_d = valid_q;
    ex_d    = ex_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ex_d    = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      ex_d    = dec_ex;
    end else if (!valid_q || bus.ex_ready) begin
      // drained or stalled: the register holds an all-zero bubble
      valid_d = 1'b0;
      ex_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

  assign bus.if_ready   = if_ready;
  assign bus.ex_valid   = valid_q;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_rs1_val = ex_q.rs1_val;
  assign bus.ex_rs2_val = ex_q.rs2_val;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_rs1     = ex_q.rs1;
  assign bus.ex_rs2     = ex_q.rs2;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Two instances share stimulus: u1 (RV32I, bypass on) and u2 (RV32E, bypass
// off). A decode table and hand sequences cover the multi-cycle corners;
// a randomized phase checks u1 against a behavioural model every cycle.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32)) b1 ();
  id_stage_pipe_if #(.XLEN(32)) b2 ();

  id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  id_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS(0)) u2 (.clk(clk), .reset(reset), .bus(b2));

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] ctrl;
    logic        ill;
  } st_t;

  typedef struct packed {
    logic        u1;
    logic        u2;
    logic        ud;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd);
    b1.if_valid = v;   b2.if_valid = v;
    b1.if_inst  = inst; b2.if_inst = inst;
    b1.if_pc    = pc;  b2.if_pc    = pc;
    b1.ex_ready = rdy; b2.ex_ready = rdy;
    b1.flush    = fl;  b2.flush    = fl;
    b1.wb_we    = we;  b2.wb_we    = we;
    b1.wb_rd    = wrd; b2.wb_rd    = wrd;
    b1.wb_data  = wd;  b2.wb_data  = wd;
  endtask

  function automatic st_t dut1_state();
    st_t s;
    s.valid = b1.ex_valid;   s.pc   = b1.ex_pc;
    s.rs1v  = b1.ex_rs1_val; s.rs2v = b1.ex_rs2_val;
    s.imm   = b1.ex_imm;     s.rd   = b1.ex_rd;
    s.rs1   = b1.ex_rs1;     s.rs2  = b1.ex_rs2;
    s.ctrl  = b1.ex_ctrl;    s.ill  = b1.ex_illegal;
    return s;
  endfunction

  // Reference decode from the ISA encoding rules.
  function automatic dec_t ref_decode(input logic [31:0] w, input int nregs);
    dec_t d;
    logic signed [31:0] sw;
    logic [31:0] sgn, i_imm, s_imm, b_imm, j_imm;
    logic mr, mw, rw, as, ok;
    logic [1:0] mtr, jp;
    logic [3:0] op;
    sw    = w;
    sgn   = 32'(sw >>> 31);
    i_imm = 32'(sw >>> 20);
    s_imm = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
    b_imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    j_imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    d = '0; mr = 0; mw = 0; rw = 0; as = 0; mtr = 0; jp = 0; ok = 1;
    op = {1'b0, w[14:12]};
    case (w[6:0])
      7'h37, 7'h17: begin d.ud = 1; rw = 1; as = 1; d.imm = w & 32'hFFFF_F000; end
      7'h6F: begin d.ud = 1; rw = 1; as = 1; mtr = 2; jp = 1; d.imm = j_imm; end
      7'h67: begin d.u1 = 1; d.ud = 1; rw = 1; as = 1; mtr = 2; jp = 2; d.imm = i_imm; end
      7'h63: begin d.u1 = 1; d.u2 = 1; jp = 3; d.imm = b_imm; end
      7'h03: begin d.u1 = 1; d.ud = 1; mr = 1; rw = 1; as = 1; mtr = 1; d.imm = i_imm; end
      7'h23: begin d.u1 = 1; d.u2 = 1; mw = 1; as = 1; d.imm = s_imm; end
      7'h13: begin
        d.u1 = 1; d.ud = 1; rw = 1; as = 1; d.imm = i_imm;
        if (w[14:12] == 3'd5) op[3] = w[30];
      end
      7'h33: begin d.u1 = 1; d.u2 = 1; d.ud = 1; rw = 1; op[3] = w[30]; end
      default: ok = 0;
    endcase
    if (d.u1 && int'(w[19:15]) >= nregs) ok = 0;
    if (d.u2 && int'(w[24:20]) >= nregs) ok = 0;
    if (d.ud && int'(w[11:7])  >= nregs) ok = 0;
    d.ill  = !ok;
    d.ctrl = ok ? {mr, mw, rw, as, mtr, jp, op} : 12'h000;
    return d;
  endfunction

  // model state
  st_t         m, mn;
  logic [31:0] mregs [32];

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && wrd == idx) return wd;
    return mregs[idx];
  endfunction

  vec_t        tbl [12];
  logic [6:0]  ops [10];

  initial begin
    logic [31:0] inst, pc, wd;
    logic        v, rdy, fl, we, stall, rdy_exp, acc;
    logic [4:0]  wrd, r1, r2;
    dec_t        d;

    tbl[0]  = '{32'hFFB00093, 32'hFFFFFFFB, 12'h300, 5'd1, 1'b0}; // ADDI x1,x0,-5
    tbl[1]  = '{32'h123452B7, 32'h12345000, 12'h305, 5'd5, 1'b0}; // LUI x5
    tbl[2]  = '{32'h0020A423, 32'h00000008, 12'h502, 5'd0, 1'b0}; // SW x2,8(x1)
    tbl[3]  = '{32'hFE208EE3, 32'hFFFFFFFC, 12'h030, 5'd0, 1'b0}; // BEQ -4
    tbl[4]  = '{32'h008000EF, 32'h00000008, 12'h390, 5'd1, 1'b0}; // JAL x1,8
    tbl[5]  = '{32'h00008067, 32'h00000000, 12'h3A0, 5'd0, 1'b0}; // JALR x0,0(x1)
    tbl[6]  = '{32'h0000A103, 32'h00000000, 12'hB42, 5'd2, 1'b0}; // LW x2,0(x1)
    tbl[7]  = '{32'h4020D193, 32'h00000402, 12'h30D, 5'd3, 1'b0}; // SRAI x3,x1,2
    tbl[8]  = '{32'h402081B3, 32'h00000000, 12'h208, 5'd3, 1'b0}; // SUB x3,x1,x2
    tbl[9]  = '{32'h00001217, 32'h00001000, 12'h301, 5'd4, 1'b0}; // AUIPC x4,1
    tbl[10] = '{32'h0000000B, 32'h00000000, 12'h000, 5'd0, 1'b1}; // custom-0
    tbl[11] = '{32'hFFFFFFFF, 32'h00000000, 12'h000, 5'd0, 1'b1};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};

    // ---- reset ----
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk("rst_state", 256'(dut1_state()), 256'(0));
    @(negedge clk) reset = 1'b1;
    #1 chk("rst_if_ready", 256'(b1.if_ready), 256'(1));

    // ---- decode table ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) drive(1, tbl[i].inst, 32'h100 + 32'(4 * i), 1, 0, 0, 0, 0);
      #1 chk("tbl_if_ready", 256'(b1.if_ready), 256'(1));
      @(posedge clk); #1;
      chk("tbl_valid", 256'(b1.ex_valid), 256'(1));
      chk("tbl_pc", 256'(b1.ex_pc), 256'(32'h100 + 32'(4 * i)));
      chk("tbl_imm", 256'(b1.ex_imm), 256'(tbl[i].imm));
      chk("tbl_ctrl", 256'(b1.ex_ctrl), 256'(tbl[i].ctrl));
      chk("tbl_rd", 256'(b1.ex_rd), 256'(tbl[i].rd));
      chk("tbl_illegal", 256'(b1.ex_illegal), 256'(tbl[i].ill));
    end

    // ---- load-use: one bubble ----
    @(negedge clk) drive(1, 32'h0000A103, 32'h200, 1, 0, 0, 0, 0);
    @(negedge clk) drive(1, 32'h002101B3, 32'h204, 1, 0, 0, 0, 0);
    #1 chk("lu_if_ready_low", 256'(b1.if_ready), 256'(0));
    @(posedge clk); #1;
    chk("lu_bubble_valid", 256'(b1.ex_valid), 256'(0));
    chk("lu_bubble_ctrl", 256'(b1.ex_ctrl), 256'(0));
    @(negedge clk); #1 chk("lu_if_ready_back", 256'(b1.if_ready), 256'(1));
    @(posedge clk); #1;
    chk("lu_add_valid", 256'(b1.ex_valid), 256'(1));
    chk("lu_add_pc", 256'(b1.ex_pc), 256'(32'h204));

    // ---- write-back bypass vs old value ----
    @(negedge clk) drive(0, 0, 0, 1, 0, 1, 5'd5, 32'h1111);
    @(negedge clk) drive(1, 32'h00028333, 32'h300, 1, 0, 1, 5'd5, 32'h1234);
    @(posedge clk); #1;
    chk("byp_on", 256'(b1.ex_rs1_val), 256'(32'h1234));
    chk("byp_off", 256'(b2.ex_rs1_val), 256'(32'h1111));
    @(negedge clk) drive(1, 32'h00028333, 32'h304, 1, 0, 0, 0, 0);
    @(posedge clk); #1 chk("byp_off_committed", 256'(b2.ex_rs1_val), 256'(32'h1234));

    // ---- hold for 3 cycles then release ----
    @(negedge clk) drive(1, 32'hFFB00093, 32'h400, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) drive(1, 32'h402081B3, 32'h404, 0, 0, 0, 0, 0);
      #1 chk("hold_if_ready", 256'(b1.if_ready), 256'(0));
      @(posedge clk); #1;
      chk("hold_state", 256'({b1.ex_valid, b1.ex_pc, b1.ex_imm, b1.ex_ctrl, b1.ex_rd}),
          256'({1'b1, 32'h400, 32'hFFFFFFFB, 12'h300, 5'd1}));
    end
    @(negedge clk) drive(1, 32'h402081B3, 32'h404, 1, 0, 0, 0, 0);
    #1 chk("release_if_ready", 256'(b1.if_ready), 256'(1));
    @(posedge clk); #1 chk("release_pc", 256'(b1.ex_pc), 256'(32'h404));

    // ---- flush ----
    @(negedge clk) drive(1, 32'hFFB00093, 32'h500, 1, 1, 0, 0, 0);
    #1 chk("flush_if_ready", 256'(b1.if_ready), 256'(0));
    @(posedge clk); #1;
    chk("flush_valid", 256'(b1.ex_valid), 256'(0));
    chk("flush_pc_absent", 256'(b1.ex_pc == 32'h500), 256'(0));
    @(negedge clk) drive(1, 32'hFFB00093, 32'h510, 1, 0, 0, 0, 0);
    @(negedge clk) drive(1, 32'hFFB00093, 32'h514, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("flush_hold_valid", 256'(b1.ex_valid), 256'(0));
    chk("flush_hold_pc_absent", 256'(b1.ex_pc == 32'h514), 256'(0));

    // ---- RV32E illegal index, x0 and out-of-range writes ----
    @(negedge clk) drive(1, 32'h00208A33, 32'h600, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rv32e_illegal", 256'({b2.ex_valid, b2.ex_illegal, b2.ex_ctrl}), 256'({1'b1, 1'b1, 12'h000}));
    chk("rv32i_legal", 256'({b1.ex_illegal, b1.ex_ctrl}), 256'({1'b0, 12'h200}));
    @(negedge clk) drive(1, 32'h000003B3, 32'h604, 1, 0, 1, 5'd0, 32'hDEAD);
    @(posedge clk); #1 chk("x0_bypass_zero", 256'(b1.ex_rs1_val), 256'(0));
    @(negedge clk) drive(0, 0, 0, 1, 0, 1, 5'd17, 32'hBEEF);
    @(negedge clk) drive(1, 32'h000083B3, 32'h608, 1, 0, 0, 0, 0);
    @(posedge clk); #1 chk("rv32e_wr17_no_alias", 256'(b2.ex_rs1_val), 256'(0));

    // ---- reset while held ----
    @(negedge clk) drive(1, 32'hFFB00093, 32'h700, 1, 0, 0, 0, 0);
    @(negedge clk) drive(1, 32'hFFB00093, 32'h704, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 chk("reset_mid_hold", 256'(dut1_state()), 256'(0));
    @(negedge clk) reset = 1'b1;

    // ---- randomized phase against the model ----
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 11) % 10 == 0 && $urandom_range(0, 1) == 1 ? 5 : $urandom_range(0, 9)];
      inst[11:7]  = 5'($urandom_range(0, 3));
      inst[19:15] = 5'($urandom_range(0, 3));
      inst[24:20] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) inst[6:0] = 7'h03;
      pc  = $urandom;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      we  = $urandom_range(0, 1) == 1;
      wrd = 5'($urandom_range(0, 3));
      wd  = $urandom;
      drive(v, inst, pc, rdy, fl, we, wrd, wd);
      #1;
      d  = ref_decode(inst, 32);
      r1 = inst[19:15];
      r2 = inst[24:20];
      stall = m.valid && m.ctrl[11] && m.rd != 0 &&
              ((d.u1 && m.rd == r1) || (d.u2 && m.rd == r2));
      rdy_exp = (!m.valid || rdy) && !stall && !fl;
      chk("rnd_if_ready", 256'(b1.if_ready), 256'(rdy_exp));
      acc = v && rdy_exp;
      mn  = m;
      if (fl || (!acc && (!m.valid || rdy))) begin
        mn = '0;
      end else if (acc) begin
        mn.valid = 1;
        mn.pc    = pc;
        mn.rs1v  = d.u1 ? mread(r1, we, wrd, wd) : 32'h0;
        mn.rs2v  = d.u2 ? mread(r2, we, wrd, wd) : 32'h0;
        mn.imm   = d.imm;
        mn.rd    = d.ud ? inst[11:7] : 5'd0;
        mn.rs1   = d.u1 ? r1 : 5'd0;
        mn.rs2   = d.u2 ? r2 : 5'd0;
        mn.ctrl  = d.ctrl;
        mn.ill   = d.ill;
      end
      if (we && wrd != 0) mregs[wrd] = wd;
      @(posedge clk); #1;
      m = mn;
      chk("rnd_ex_state", 256'(dut1_state()), 256'(m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
